// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_pkg
// Brief   : Register map, STATUS bit positions and FSM encoding for uart_tx_mmio
// Revision: 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    localparam logic [3:0] C_REG_TXDATA = 4'h0;
    localparam logic [3:0] C_REG_STATUS = 4'h4;
    localparam logic [3:0] C_REG_CTRL   = 4'h8;

    localparam int C_STAT_BUSY    = 0;
    localparam int C_STAT_FULL    = 1;
    localparam int C_STAT_EMPTY   = 2;
    localparam int C_STAT_OVF     = 3;
    localparam int C_STAT_CNT_LSB = 4;
    localparam int C_STAT_CNT_MSB = 7;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_START = 2'd1;
    localparam logic [1:0] C_ST_DATA  = 2'd2;
    localparam logic [1:0] C_ST_STOP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : Byte-wide synchronous FIFO; the parent gates push/pop legality
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage is not reset; only pointers and count define validity
    always_ff @(posedge clock) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == C_DEPTH);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_mmio
// Brief   : Memory-mapped 8N1 UART transmitter with TX FIFO and polled status
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_mmio
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        sel,
    input  logic [3:0]  addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] C_BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic [1:0]    r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_enable;
    logic          r_overflow;

    logic          w_baud_last;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push_ok;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic          w_ctrl_wr;
    logic [7:0]    w_fifo_dout;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic [31:0]   w_count_ext;
    logic [31:0]   w_status;
    logic          w_unused;

    assign w_baud_last = (r_baud == C_BAUD_LAST);
    assign w_pop       = r_enable && !w_fifo_empty &&
                         ((r_state == C_ST_IDLE) ||
                          ((r_state == C_ST_STOP) && w_baud_last));

    // A push into a full FIFO still lands when the head leaves on the same edge
    assign w_push_req = sel && wr_en && (addr[3:2] == C_REG_TXDATA[3:2]);
    assign w_push_ok  = w_push_req && (!w_fifo_full || w_pop);
    assign w_ovf_set  = w_push_req && !w_push_ok;
    assign w_ovf_clr  = sel && wr_en && (addr[3:2] == C_REG_STATUS[3:2]) && wdata[C_STAT_OVF];
    assign w_ctrl_wr  = sel && wr_en && (addr[3:2] == C_REG_CTRL[3:2]);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (w_push_ok),
        .pop   (w_pop),
        .din   (wdata[7:0]),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_enable   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_enable <= wdata[0];
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state   <= C_ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (w_pop) begin
                        r_state <= C_ST_START;
                        r_shift <= w_fifo_dout;
                        r_baud  <= '0;
                        r_tx    <= 1'b0;
                    end
                end
                C_ST_START: begin
                    if (w_baud_last) begin
                        r_baud    <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= C_ST_DATA;
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                C_ST_DATA: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= C_ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                C_ST_STOP: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        // Back-to-back frames: next start bit follows the stop bit directly
                        if (w_pop) begin
                            r_state <= C_ST_START;
                            r_shift <= w_fifo_dout;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= C_ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= C_ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx          = r_tx;
    assign busy        = (r_state != C_ST_IDLE);
    assign w_count_ext = 32'(w_fifo_count);

    always_comb begin
        w_status                                = 32'h0;
        w_status[C_STAT_BUSY]                   = busy;
        w_status[C_STAT_FULL]                   = w_fifo_full;
        w_status[C_STAT_EMPTY]                  = w_fifo_empty;
        w_status[C_STAT_OVF]                    = r_overflow;
        w_status[C_STAT_CNT_MSB:C_STAT_CNT_LSB] = w_count_ext[3:0];
    end

    always_comb begin
        rdata = 32'h0;
        if (sel && rd_en) begin
            case (addr[3:2])
                C_REG_STATUS[3:2]: rdata = w_status;
                C_REG_CTRL[3:2]:   rdata = {31'h0, r_enable};
                default:           rdata = 32'h0;
            endcase
        end
    end

    assign w_unused = &{1'b0, addr[1:0], wdata[31:8], w_count_ext[31:4]};

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_mmio
// Brief   : Directed self-checking bench for uart_tx_mmio (CLKS_PER_BIT=4, depth 4)
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_mmio;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        rst;
    logic        sel;
    logic [3:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    uart_tx_mmio #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .sel   (sel),
        .addr  (addr),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .wdata (wdata),
        .rdata (rdata),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clock);
        sel = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
        @(posedge clock);
        #1;
        sel = 1'b0; wr_en = 1'b0; addr = 4'h0; wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        sel = 1'b1; rd_en = 1'b1; addr = a;
        #1;
        d = rdata;
        sel = 1'b0; rd_en = 1'b0; addr = 4'h0;
    endtask

    // Returns 1 time unit after edge number 'target'
    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [9:0]  frm;
        logic [7:0]  b;
        logic [7:0]  exp_bytes [4];
        logic        seen_activity;
        int          n;

        exp_bytes[0] = 8'hA1; exp_bytes[1] = 8'hB2;
        exp_bytes[2] = 8'hC3; exp_bytes[3] = 8'hD4;

        rst = 1'b1; sel = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = 4'h0; wdata = 32'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        rst = 1'b0;
        @(posedge clock);
        #1;

        // Reset state
        check_eq("reset_tx", {31'h0, tx}, 32'h1);
        check_eq("reset_busy", {31'h0, busy}, 32'h0);
        bus_read(4'h4, rd);
        check_eq("reset_status", rd, 32'h0000_0004);
        sel = 1'b1; rd_en = 1'b0; addr = 4'h4;
        #1;
        check_eq("rdata_gated_rd_en", rdata, 32'h0);
        sel = 1'b0;

        // Single frame of 0x55
        bus_write(4'h8, 32'h1);
        bus_write(4'h0, 32'h55);
        n = cyc;
        check_eq("f55_tx_before_pop", {31'h0, tx}, 32'h1);
        wait_until(n + 1);
        check_eq("f55_tx_falls", {31'h0, tx}, 32'h0);
        frm = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 10; i++) begin
            wait_until(n + 3 + 4 * i);
            check_eq($sformatf("f55_bit%0d", i), {31'h0, tx}, {31'h0, frm[i]});
        end
        wait_until(n + 40);
        check_eq("f55_busy_last", {31'h0, busy}, 32'h1);
        wait_until(n + 41);
        check_eq("f55_busy_drop", {31'h0, busy}, 32'h0);

        // Fill with enable off, overflow on fifth byte, then clear
        bus_write(4'h8, 32'h0);
        bus_write(4'h0, 32'hA1);
        bus_write(4'h0, 32'hB2);
        bus_write(4'h0, 32'hC3);
        bus_write(4'h0, 32'hD4);
        bus_write(4'h0, 32'hE5);
        bus_read(4'h4, rd);
        check_eq("ovf_status", rd, 32'h0000_004A);
        bus_write(4'h4, 32'h8);
        bus_read(4'h4, rd);
        check_eq("ovf_cleared", rd, 32'h0000_0042);
        bus_read(4'h0, rd);
        check_eq("txdata_reads0", rd, 32'h0);
        bus_write(4'hC, 32'hFFFF_FFFF);
        bus_read(4'hC, rd);
        check_eq("reg_c_reads0", rd, 32'h0);
        bus_read(4'h8, rd);
        check_eq("ctrl_off", rd, 32'h0);
        bus_read(4'h4, rd);
        check_eq("reg_c_no_effect", rd, 32'h0000_0042);

        // Drain four back-to-back frames
        bus_write(4'h8, 32'h1);
        bus_read(4'h8, rd);
        check_eq("ctrl_on", rd, 32'h1);
        n = cyc;
        for (int f = 0; f < 4; f++) begin
            b = 8'h00;
            wait_until(n + 1 + 40 * f);
            check_eq($sformatf("b2b_start_edge%0d", f), {31'h0, tx}, 32'h0);
            for (int i = 0; i < 10; i++) begin
                wait_until(n + 3 + 40 * f + 4 * i);
                if (i == 0) begin
                    check_eq($sformatf("b2b_start%0d", f), {31'h0, tx}, 32'h0);
                end else if (i == 9) begin
                    check_eq($sformatf("b2b_stop%0d", f), {31'h0, tx}, 32'h1);
                    check_eq($sformatf("b2b_busy%0d", f), {31'h0, busy}, 32'h1);
                end else begin
                    b[i-1] = tx;
                end
            end
            check_eq($sformatf("b2b_byte%0d", f), {24'h0, b}, {24'h0, exp_bytes[f]});
        end
        wait_until(n + 160);
        check_eq("b2b_busy_end", {31'h0, busy}, 32'h1);
        wait_until(n + 161);
        check_eq("b2b_busy_drop", {31'h0, busy}, 32'h0);
        bus_read(4'h4, rd);
        check_eq("b2b_status_empty", rd, 32'h0000_0004);

        // Push into a full FIFO on the same edge as the STOP->START pop
        bus_write(4'h8, 32'h0);
        bus_write(4'h0, 32'h11);
        bus_write(4'h0, 32'h22);
        bus_write(4'h0, 32'h33);
        bus_write(4'h0, 32'h44);
        bus_read(4'h4, rd);
        check_eq("full_idle_status", rd, 32'h0000_0042);
        bus_write(4'h8, 32'h1);
        n = cyc;
        bus_write(4'h0, 32'h55);
        bus_read(4'h4, rd);
        check_eq("full_idle_pop_push", rd, 32'h0000_0043);
        wait_until(n + 40);
        bus_read(4'h4, rd);
        check_eq("full_before_stop_pop", rd, 32'h0000_0043);
        bus_write(4'h0, 32'h66);
        check_eq("full_push_edge", cyc, n + 41);
        bus_read(4'h4, rd);
        check_eq("full_stop_pop_push", rd, 32'h0000_0043);
        check_eq("full_next_start", {31'h0, tx}, 32'h0);

        // Asynchronous reset during a start bit
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_tx", {31'h0, tx}, 32'h1);
        check_eq("async_rst_busy", {31'h0, busy}, 32'h0);
        @(negedge clock);
        rst = 1'b0;

        // Reset during DATA bit 3 of 0x0F with two bytes queued
        bus_write(4'h8, 32'h1);
        bus_write(4'h0, 32'h0F);
        n = cyc;
        bus_write(4'h0, 32'hAA);
        bus_write(4'h0, 32'hBB);
        bus_read(4'h4, rd);
        check_eq("queued_two", rd, 32'h0000_0021);
        wait_until(n + 15);
        check_eq("data_bit2", {31'h0, tx}, 32'h1);
        wait_until(n + 19);
        check_eq("data_bit3", {31'h0, tx}, 32'h1);
        check_eq("data_bit3_busy", {31'h0, busy}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_data_tx", {31'h0, tx}, 32'h1);
        check_eq("rst_data_busy", {31'h0, busy}, 32'h0);
        @(negedge clock);
        rst = 1'b0;
        #1;
        bus_read(4'h4, rd);
        check_eq("rst_data_status", rd, 32'h0000_0004);
        seen_activity = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0) seen_activity = 1'b1;
        end
        check_eq("rst_no_activity", {31'h0, seen_activity}, 32'h0);
        bus_read(4'h4, rd);
        check_eq("rst_status_after", rd, 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the data-memory side of the RISCVunicycle single-cycle core; consumes the core's store/load traffic for its address window.
- Stores to TXDATA push bytes into a small FIFO; a baud-timed FSM serializes them 8N1 on `tx`.
- Single-cycle core cannot stall, so software polls STATUS. Reads are combinational; writes take effect on the clock edge.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range ≥2.
- FIFO_DEPTH, 4, byte entries in the TX FIFO; must be a power of 2, ≥2.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- sel  in  1  address decode hit for this peripheral's window, from the core.
- addr  in  4  byte offset within the window; bits [1:0] are ignored.
- wr_en  in  1  store strobe, qualified by sel.
- rd_en  in  1  load strobe, qualified by sel.
- wdata  in  32  store data.
- rdata  out  32  load data; combinational.
- tx  out  1  serial line, registered; idles high.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Register map:
  - 0x0 TXDATA: a write pushes wdata[7:0]; reads return 0.
  - 0x4 STATUS, read-only except bit3:
    - bit0 busy, bit1 fifo_full, bit2 fifo_empty, bit3 overflow (sticky).
    - bits[7:4] fifo count, zero-extended.
    - Writing with wdata[3]=1 clears overflow.
  - 0x8 CTRL: bit0 enable, read/write; all other bits read 0.
  - 0xC: reads 0; writes are ignored.
- rdata is 0 whenever sel=0 or rd_en=0.
- Reset values: tx=1, busy=0, FIFO empty (count=0), overflow=0, enable=0, FSM in IDLE, baud counter=0, bit index=0.
- A reset asserted mid-frame forces tx=1 immediately; the frame and all queued bytes are discarded.
- Push rules:
  - A push occurs when sel & wr_en and addr=0x0.
  - The push is accepted if the FIFO is not full, or if the FSM pops in the same cycle.
  - Otherwise the byte is dropped and overflow is set on that edge.
  - Push, pop and overflow-clear can all occur on the same edge. If a dropped push coincides with a clear, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if enable=1 and the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if enable=1 and the FIFO is non-empty, pop and go to START on the same edge (no idle gap); otherwise go to IDLE.
- Latency: a push at edge N is visible as non-empty after N. The pop is at edge N+1, and tx falls at edge N+1. Total frame length is 10*CLKS_PER_BIT cycles.
- busy=1 in START, DATA and STOP.
- Clearing enable mid-frame completes the current frame; no new pop occurs.
- FIFO pointers wrap modulo FIFO_DEPTH. count holds values 0..FIFO_DEPTH, so it is one bit wider than the pointers.
- The baud counter counts 0..CLKS_PER_BIT-1 and is sized with $clog2.

Decomposition:
- Shared package `uart_tx_pkg`:
  - Register offsets: TXDATA=4'h0, STATUS=4'h4, CTRL=4'h8.
  - STATUS bit positions.
  - FSM state encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
- One sub-module `uart_tx_fifo`:
  - Synchronous FIFO with parameterized depth.
  - Ports: push, pop, din[7:0], dout[7:0], full, empty, count.
  - Same clock and asynchronous active-high reset as the parent.
- The top level holds register decode, the FSM, the baud counter and the shift register.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset → tx=1, busy=0, STATUS read = 0x0000_0004.
- Write CTRL=1, then TXDATA=0x55 → tx falls the next edge. Sampling mid-bit every 4 cycles gives 0,1,0,1,0,1,0,1,0,1. busy drops after 40 cycles.
- With enable=0, write 0xA1, 0xB2, 0xC3, 0xD4, 0xE5 → STATUS=0x0000_004A (count=4, full, overflow). Clear with STATUS write 0x8 → 0x0000_0042.
- Then set enable=1 → four back-to-back frames (160 cycles), tx never high between a stop bit and the next start bit. Bytes emerge in order A1, B2, C3, D4.
- With the FIFO full and a frame ending, write TXDATA in the same cycle as the STOP→START pop → byte accepted, count stays 4, overflow stays 0.
- Assert rst during DATA bit 3 of 0x0F with 2 bytes queued → tx=1 asynchronously. After release: STATUS=0x0000_0004, no further tx activity.
